// File: rtl/mips_decode_pkg.sv
// MIPS instruction-format constants and the decoded-field struct shared by
// the fetch/decode buffer and the decode stage.
package mips_decode_pkg;

   localparam int WORD_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM16_LSB  = 0;
   localparam int TARGET_LSB = 0;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm16;
      logic [25:0] target;
   } instr_fields_t;

endpackage

// File: rtl/instr_fields.sv
// Pure combinational slicer from a 32-bit MIPS word to its named fields.
module instr_fields
   import mips_decode_pkg::*;
(
   input  logic [WORD_W-1:0] i_instr,
   output instr_fields_t     o_fields
);

   always_comb begin
      o_fields        = '0;
      o_fields.opcode = i_instr[OPCODE_LSB +: 6];
      o_fields.rs     = i_instr[RS_LSB     +: 5];
      o_fields.rt     = i_instr[RT_LSB     +: 5];
      o_fields.rd     = i_instr[RD_LSB     +: 5];
      o_fields.shamt  = i_instr[SHAMT_LSB  +: 5];
      o_fields.funct  = i_instr[FUNCT_LSB  +: 6];
      o_fields.imm16  = i_instr[IMM16_LSB  +: 16];
      o_fields.target = i_instr[TARGET_LSB +: 26];
   end

endmodule

// File: rtl/instr_decode_buf.sv
// 2-entry ready/valid skid between fetch and decode, presenting the head entry
// pre-sliced. Optional NOP dropping when INSTR_DECODE_BUF_NOP_SQUASH_EN is defined.
module instr_decode_buf
   import mips_decode_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [5:0]         out_opcode,
   output logic [4:0]         out_rs,
   output logic [4:0]         out_rt,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_shamt,
   output logic [5:0]         out_funct,
   output logic [15:0]        out_imm16,
   output logic [25:0]        out_target,
   output logic               out_is_rtype,
   output logic               out_is_jtype,
   output logic               out_is_itype
`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
   ,
   output logic               nop_squashed
`endif
);

   logic [INSTR_W-1:0] r_instr [2];
   logic [PC_W-1:0]    r_pc    [2];
   logic               r_wptr;
   logic               r_rptr;
   logic [1:0]         r_count;

   logic               w_push;
   logic               w_pop;
   logic               w_write;
   instr_fields_t      w_fields;

   // Handshakes depend only on registered occupancy, never on the other side.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
   logic r_nop_squashed;
   logic w_is_nop;

   assign w_is_nop     = (in_instr == '0);
   assign w_write      = w_push && !w_is_nop;
   assign nop_squashed = r_nop_squashed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_nop_squashed <= 1'b0;
      else        r_nop_squashed <= w_push && w_is_nop && !flush;
   end
`else
   assign w_write = w_push;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_instr[i] <= '0;
            r_pc[i]    <= '0;
         end
      end else if (flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_write) begin
            r_instr[r_wptr] <= in_instr;
            r_pc[r_wptr]    <= in_pc;
            r_wptr          <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_instr = r_instr[r_rptr];
   assign out_pc    = r_pc[r_rptr];

   instr_fields u_fields (
      .i_instr  (out_instr),
      .o_fields (w_fields)
   );

   assign out_opcode = w_fields.opcode;
   assign out_rs     = w_fields.rs;
   assign out_rt     = w_fields.rt;
   assign out_rd     = w_fields.rd;
   assign out_shamt  = w_fields.shamt;
   assign out_funct  = w_fields.funct;
   assign out_imm16  = w_fields.imm16;
   assign out_target = w_fields.target;

   // Stale head fields are visible when empty; only the class flags are gated.
   assign out_is_rtype = out_valid && (w_fields.opcode == OP_RTYPE);
   assign out_is_jtype = out_valid && ((w_fields.opcode == OP_J) || (w_fields.opcode == OP_JAL));
   assign out_is_itype = out_valid && !out_is_rtype && !out_is_jtype;

endmodule

// File: tb/tb_instr_decode_buf.sv
// Scoreboarded bench for instr_decode_buf; covers the NOP-squash option when
// INSTR_DECODE_BUF_NOP_SQUASH_EN is defined.
module tb_instr_decode_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm16;
   logic [25:0] out_target;
   logic        out_is_rtype, out_is_jtype, out_is_itype;
`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
   logic        nop_squashed;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] q [$];

   always #5 clk = ~clk;

   instr_decode_buf #(.PC_W(32), .INSTR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_opcode   (out_opcode),
      .out_rs       (out_rs),
      .out_rt       (out_rt),
      .out_rd       (out_rd),
      .out_shamt    (out_shamt),
      .out_funct    (out_funct),
      .out_imm16    (out_imm16),
      .out_target   (out_target),
      .out_is_rtype (out_is_rtype),
      .out_is_jtype (out_is_jtype),
      .out_is_itype (out_is_itype)
`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
      ,
      .nop_squashed (nop_squashed)
`endif
   );

   // Scoreboard monitor: inputs are stable at the edge, outputs are pre-edge values.
   logic push_kept;
   always_comb begin
      push_kept = in_valid && in_ready;
`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
      if (in_instr == 32'h0) push_kept = 1'b0;
`endif
   end

   always @(posedge clk) begin
      logic [63:0] exp;
      if (rst_n) begin
         n_tests++;
         if (dut.r_count > 2'd2) begin
            n_fail++;
            $display("FAIL count_range: count=%0d required<=2", dut.r_count);
         end
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready) begin
               n_tests++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL pop_order: popped pc=%h instr=%h, required nothing", out_pc, out_instr);
               end else begin
                  exp = q.pop_front();
                  if ({out_pc, out_instr} !== exp) begin
                     n_fail++;
                     $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h",
                              out_pc, out_instr, exp[63:32], exp[31:0]);
                  end
               end
            end
            if (push_kept) q.push_back({in_pc, in_instr});
         end
      end
   end

   task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++;
      if ({out_valid, in_ready, out_instr, out_pc} !== {1'b0, 1'b1, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_initial: valid=%b ready=%b instr=%h pc=%h required 0/1/0/0",
                  out_valid, in_ready, out_instr, out_pc);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_one(32'h0040_1000, 32'h2001_1111);
      push_one(32'h0040_1004, 32'h2002_2222);
      n_tests++;
      if (dut.r_count !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_fill: count=%0d required 2", dut.r_count);
      end
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      n_tests++;
      if ({out_valid, in_ready, out_instr, out_pc, out_opcode, out_rt, out_imm16} !== {1'b0, 1'b1, 64'h0, 6'h0, 5'h0, 16'h0}) begin
         n_fail++;
         $display("FAIL reset_async: valid=%b ready=%b instr=%h pc=%h required 0/1/0/0",
                  out_valid, in_ready, out_instr, out_pc);
      end
      n_tests++;
      if ({out_is_rtype, out_is_jtype, out_is_itype} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: r/j/i=%b%b%b required 000", out_is_rtype, out_is_jtype, out_is_itype);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_one(32'h0040_0000, 32'h2008_FFFF);
      n_tests++;
      if ({out_opcode, out_rs, out_rt, out_imm16, out_is_itype, out_pc} !==
          {6'h08, 5'd0, 5'd8, 16'hFFFF, 1'b1, 32'h0040_0000}) begin
         n_fail++;
         $display("FAIL reset_itype: op=%h rs=%0d rt=%0d imm=%h itype=%b pc=%h required 08/0/8/ffff/1/00400000",
                  out_opcode, out_rs, out_rt, out_imm16, out_is_itype, out_pc);
      end
      pop_one();
   endtask

   task automatic test_rtype();
      push_one(32'h0040_0004, 32'h0109_5020);
      n_tests++;
      if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_is_rtype, out_is_itype, out_is_jtype} !==
          {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rtype_fields: op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h r/i/j=%b%b%b required 00/8/9/10/0/20/100",
                  out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_is_rtype, out_is_itype, out_is_jtype);
      end
      pop_one();
   endtask

   task automatic test_jtype();
      push_one(32'h0040_0008, 32'h0800_0040);
      n_tests++;
      if ({out_opcode, out_is_jtype, out_is_rtype, out_is_itype, out_target} !== {6'h02, 3'b100, 26'h40}) begin
         n_fail++;
         $display("FAIL j_fields: op=%h j/r/i=%b%b%b target=%h required 02/100/0000040",
                  out_opcode, out_is_jtype, out_is_rtype, out_is_itype, out_target);
      end
      pop_one();
      push_one(32'h0040_000C, 32'h0C00_0040);
      n_tests++;
      if ({out_opcode, out_is_jtype, out_is_itype, out_target} !== {6'h03, 2'b10, 26'h40}) begin
         n_fail++;
         $display("FAIL jal_fields: op=%h jtype=%b itype=%b target=%h required 03/1/0/0000040",
                  out_opcode, out_is_jtype, out_is_itype, out_target);
      end
      pop_one();
      n_tests++;
      if ({out_valid, out_is_jtype} !== 2'b00) begin
         n_fail++;
         $display("FAIL empty_gate: valid=%b jtype=%b required 0/0", out_valid, out_is_jtype);
      end
   endtask

   task automatic test_backpressure();
      push_one(32'h0000_0100, 32'h2001_000A);
      push_one(32'h0000_0104, 32'h2001_000B);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full: in_ready=%b required 0", in_ready);
      end
      in_valid = 1'b1;
      in_pc    = 32'h0000_0108;
      in_instr = 32'h2001_000C;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if ({in_ready, out_instr} !== {1'b0, 32'h2001_000A}) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b head=%h required 0/2001000a", in_ready, out_instr);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready, out_instr} !== {1'b1, 32'h2001_000B}) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%b head=%h required 1/2001000b", in_ready, out_instr);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if ({dut.r_count, out_instr} !== {2'd1, 32'h2001_000C}) begin
         n_fail++;
         $display("FAIL bp_third: count=%0d head=%h required 1/2001000c", dut.r_count, out_instr);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++;
      if ((out_valid !== 1'b0) || (q.size() != 0)) begin
         n_fail++;
         $display("FAIL bp_drain: valid=%b pending=%0d required 0/0", out_valid, q.size());
      end
   endtask

   task automatic test_flush();
      push_one(32'h0000_0200, 32'h2001_0A0A);
      push_one(32'h0000_0204, 32'h2001_0B0B);
      in_valid = 1'b1;
      in_pc    = 32'h0000_0208;
      in_instr = 32'h2001_0D0D;
      flush    = 1'b1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready: in_ready=%b required 0 while full", in_ready);
      end
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      n_tests++;
      if ({out_valid, in_ready, dut.r_count} !== {1'b0, 1'b1, 2'd0}) begin
         n_fail++;
         $display("FAIL flush_empty: valid=%b ready=%b count=%0d required 0/1/0", out_valid, in_ready, dut.r_count);
      end
      // Flush from count 1 with an accepted beat: the beat must also vanish.
      push_one(32'h0000_020C, 32'h2001_0C0C);
      in_valid = 1'b1;
      in_pc    = 32'h0000_0210;
      in_instr = 32'h2001_0D0E;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      n_tests++;
      if ({out_valid, dut.r_count} !== {1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL flush_drop: valid=%b count=%0d required 0/0", out_valid, dut.r_count);
      end
      push_one(32'h0000_0300, 32'h2001_0E0E);
      n_tests++;
      if ({dut.r_count, out_instr, out_pc} !== {2'd1, 32'h2001_0E0E, 32'h0000_0300}) begin
         n_fail++;
         $display("FAIL flush_after: count=%0d head=%h pc=%h required 1/20010e0e/00000300",
                  dut.r_count, out_instr, out_pc);
      end
      pop_one();
   endtask

   task automatic test_back_to_back();
      push_one(32'h0000_1000, 32'h2008_1000);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_pc    = 32'h0000_1000 + 32'(i * 4);
         in_instr = 32'h2008_1000 + 32'(i);
         @(posedge clk); #1;
         n_tests++;
         if ({dut.r_count, out_instr} !== {2'd1, 32'h2008_1000 + 32'(i)}) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: count=%0d head=%h required 1/%h",
                     i, dut.r_count, out_instr, 32'h2008_1000 + 32'(i));
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++;
      if ((out_valid !== 1'b0) || (q.size() != 0)) begin
         n_fail++;
         $display("FAIL b2b_drain: valid=%b pending=%0d required 0/0", out_valid, q.size());
      end
   endtask

`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
   task automatic test_nop_squash();
      int pulses;
      pulses = 0;
      n_tests++;
      if (nop_squashed !== 1'b0) begin
         n_fail++;
         $display("FAIL nop_idle: nop_squashed=%b required 0", nop_squashed);
      end
      in_valid = 1'b1;
      in_pc    = 32'h0000_2000;
      in_instr = 32'h0000_0000;
      @(posedge clk); #1;
      pulses += int'(nop_squashed);
      in_pc    = 32'h0000_2004;
      in_instr = 32'h2008_FFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      pulses += int'(nop_squashed);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         pulses += int'(nop_squashed);
      end
      n_tests++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL nop_pulse: pulses=%0d required 1", pulses);
      end
      n_tests++;
      if ({dut.r_count, out_instr} !== {2'd1, 32'h2008_FFFF}) begin
         n_fail++;
         $display("FAIL nop_only_real: count=%0d head=%h required 1/2008ffff", dut.r_count, out_instr);
      end
      pop_one();
   endtask
`endif

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_rtype();
      test_jtype();
      test_backpressure();
      test_flush();
      test_back_to_back();
`ifdef INSTR_DECODE_BUF_NOP_SQUASH_EN
      test_nop_squash();
`endif
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: pending=%0d required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode_buf.md
Name: instr_decode_buf

Overview:
- 2-entry ready/valid buffer between instruction fetch and decode in the MIPS datapath.
- Accepts {pc, instr} from fetch and presents the head entry with all fields sliced out.
- Its imm16 output feeds the signextend stage directly downstream.
- Absorbs one cycle of decode backpressure without a combinational ready path back to fetch, and supports a pipeline flush.

Parameters:
- PC_W, 32, width of the program-counter field carried with each instruction.
- INSTR_W, 32, instruction width; fixed at 32 for MIPS; other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept; high when occupancy < 2; registered-state only.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  address of in_instr.
- flush  in  1  discard all buffered and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes head.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  head pc.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_shamt  out  5  instr[10:6].
- out_funct  out  6  instr[5:0].
- out_imm16  out  16  instr[15:0]; goes to signextend.
- out_target  out  26  instr[25:0].
- out_is_rtype  out  1  out_valid && opcode==0.
- out_is_jtype  out  1  out_valid && opcode in {2,3}.
- out_is_itype  out  1  out_valid && neither of the above.

Behaviour:
- Storage and pointers:
  - Two entries of {pc, instr}, 1-bit write and read pointers, 2-bit count (0..2).
  - Pointers wrap 1 to 0.
- Handshakes:
  - Push = in_valid && in_ready.
  - Pop = out_valid && out_ready.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - Neither depends combinationally on the opposite handshake input.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no bypass.
- Output decode:
  - All field outputs are pure combinational slices of the head entry.
  - When count==0 the fields show the stale head contents; consumers must qualify with out_valid.
  - The is_* flags are gated by out_valid.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together (count 1): count unchanged, both pointers advance.
  - When count==2, in_ready is low, so push is impossible; pop alone gives count 1.
- Flush (synchronous, highest priority):
  - Next edge: count=0 and both pointers=0.
  - A push in the same cycle is dropped, as is any pop.
  - in_ready stays at its normal value during the flush cycle, so fetch sees its beat accepted-and-dropped.
- Reset (asserted asynchronously, including mid-operation):
  - count=0, pointers=0, storage cleared to 0.
  - Resulting outputs: out_valid=0, in_ready=1, all fields 0, all is_* flags 0.
  - No partial entry survives reset.
- Out-of-range occupancy is impossible by construction. The bench asserts count<=2 every cycle.

Optional Feature:
- Macro: INSTR_DECODE_BUF_NOP_SQUASH_EN.
- Defined:
  - A pushed instruction equal to 32'h0000_0000 (sll $0,$0,0) is accepted (handshake completes) but not written; count is unchanged.
  - If the cycle also pops, count decrements normally.
  - Adds output nop_squashed (1 bit), pulsed high for one cycle per dropped NOP, 0 at reset.
- Undefined: NOPs are buffered like any instruction and the nop_squashed port does not exist.

Decomposition:
- Package mips_decode_pkg:
  - Opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03.
  - Field bit-position localparams.
  - A packed struct for {opcode, rs, rt, rd, shamt, funct, imm16, target}.
- One natural sub-module, instr_fields: combinational slicer from a 32-bit word to the package struct. It is reused later by the decode stage.

Test Plan:
- Reset check: assert rst_n low mid-stream with count=2 -> same cycle out_valid=0, in_ready=1, all fields 0; after release, push 0x2008FFFF at pc 0x0040_0000.
  - Next cycle: opcode=0x08, rs=0, rt=8, imm16=0xFFFF, is_itype=1, out_pc=0x0040_0000.
- R-type decode: push 0x01095020 -> next cycle opcode=0, rs=8, rt=9, rd=10, shamt=0, funct=0x20, is_rtype=1.
- J-type decode: push 0x08000040 -> next cycle is_jtype=1, target=0x0000040. Push 0x0C000040 -> is_jtype=1.
- Backpressure: hold out_ready=0 and push A, B -> in_ready=0 after B.
  - Third beat C held on in_ready=0, not lost.
  - Raise out_ready -> pops A, then B, then C in order; in_ready returns high the cycle after A pops.
- Flush: with count=2 and in_valid=1 carrying D, pulse flush -> next cycle out_valid=0, count=0, D absent; subsequent push E appears alone.
- Simultaneous push/pop: at count=1, push and pop for 10 consecutive cycles -> count stays 1, output order matches input order.
- NOP squash (macro defined): push 0x00000000 then 0x2008FFFF -> nop_squashed pulses once, only 0x2008FFFF emerges.
